// File: rtl/mul_rem_pkg.sv
// rtl/mul_rem_pkg.sv - shared widths, state encoding and helpers for the multiply/remainder path
package mul_rem_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_REM_W = 4;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Counter must hold the value WIDTH itself, not just WIDTH-1.
   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/mul_rem_seq_if.sv
// rtl/mul_rem_seq_if.sv - operand/result bundle between a requester and mul_rem_seq
interface mul_rem_seq_if
   import mul_rem_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int REM_W = DEF_REM_W
);
   logic                 start;
   logic [WIDTH-1:0]     dvs;
   logic [WIDTH-1:0]     quo;
   logic [REM_W-1:0]     rem;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   prod;

   modport master (
      output start, dvs, quo, rem,
      input  busy, done, prod
   );

   modport slave (
      input  start, dvs, quo, rem,
      output busy, done, prod
   );
endinterface

// File: rtl/mul_rem_step.sv
// rtl/mul_rem_step.sv - one shift-add iteration: conditional add, then shift both operands
module mul_rem_step #(
   parameter int WIDTH = 8
) (
   input  logic [2*WIDTH-1:0] acc,
   input  logic [2*WIDTH-1:0] mcand,
   input  logic [WIDTH-1:0]   mplr,
   output logic [2*WIDTH-1:0] acc_nxt,
   output logic [2*WIDTH-1:0] mcand_nxt,
   output logic [WIDTH-1:0]   mplr_nxt
);
   always_comb begin
      acc_nxt   = mplr[0] ? (acc + mcand) : acc;
      mcand_nxt = mcand << 1;
      mplr_nxt  = mplr >> 1;
   end
endmodule

// File: rtl/mul_rem_seq.sv
// rtl/mul_rem_seq.sv - sequential prod = dvs * quo + rem, one multiplier bit per clock
module mul_rem_seq
   import mul_rem_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int REM_W = DEF_REM_W
) (
   input logic          clk,
   input logic          rst,
   mul_rem_seq_if.slave bus
);
   localparam int CW = cnt_width(WIDTH);

   state_t               state_q, state_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [2*WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]     mplr_q, mplr_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   prod_q, prod_d;
   logic                 done_q, done_d;

   logic [2*WIDTH-1:0]   step_acc, step_mcand;
   logic [WIDTH-1:0]     step_mplr;

   mul_rem_step #(.WIDTH(WIDTH)) u_step (
      .acc       (acc_q),
      .mcand     (mcand_q),
      .mplr      (mplr_q),
      .acc_nxt   (step_acc),
      .mcand_nxt (step_mcand),
      .mplr_nxt  (step_mplr)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         mcand_q <= '0;
         mplr_q  <= '0;
         cnt_q   <= '0;
         prod_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         mcand_q <= mcand_d;
         mplr_q  <= mplr_d;
         cnt_q   <= cnt_d;
         prod_q  <= prod_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      mcand_d = mcand_q;
      mplr_d  = mplr_q;
      cnt_d   = cnt_q;
      prod_d  = prod_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               acc_d   = {{(2*WIDTH-REM_W){1'b0}}, bus.rem};
               mcand_d = {{WIDTH{1'b0}}, bus.dvs};
               mplr_d  = bus.quo;
               cnt_d   = CW'(WIDTH);
               state_d = RUN;
            end
         end
         RUN: begin
            acc_d   = step_acc;
            mcand_d = step_mcand;
            mplr_d  = step_mplr;
            cnt_d   = cnt_q - CW'(1);
            // The last iteration's add lands directly in prod, not a cycle later.
            if (cnt_q == CW'(1)) begin
               prod_d  = step_acc;
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.busy = (state_q == RUN);
   assign bus.done = done_q;
   assign bus.prod = prod_q;
endmodule

// File: tb/tb_mul_rem_seq.sv
// tb/tb_mul_rem_seq.sv - scoreboard bench for mul_rem_seq with directed vectors
module tb_mul_rem_seq;
   logic clk = 1'b0;
   logic rst = 1'b0;

   int errors = 0;
   int checks = 0;
   logic [15:0] exp_q[$];

   mul_rem_seq_if #(.WIDTH(8), .REM_W(4)) bus ();

   mul_rem_seq #(.WIDTH(8), .REM_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: every done strobe must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst && bus.done === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected done", 1, 0);
         end else begin
            check("prod at done", {16'd0, bus.prod}, {16'd0, exp_q.pop_front()});
         end
      end
   end

   task automatic issue(input logic [7:0] d, input logic [7:0] q, input logic [3:0] r,
                        input logic [15:0] e, input bit push);
      @(negedge clk);
      bus.start = 1'b1;
      bus.dvs   = d;
      bus.quo   = q;
      bus.rem   = r;
      if (push) exp_q.push_back(e);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.dvs   = 8'hA5;
      bus.quo   = 8'h5A;
      bus.rem   = 4'hC;
   endtask

   task automatic wait_done(input int lat0, input string tag);
      int lat;
      bit seen;
      lat  = lat0;
      seen = 1'b0;
      while (!seen && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
         if (bus.done === 1'b1) seen = 1'b1;
         else check({tag, " busy"}, {31'd0, bus.busy}, 1);
      end
      check({tag, " done seen"}, {31'd0, seen}, 1);
      check({tag, " latency"}, lat, 8);
      check({tag, " busy at done"}, {31'd0, bus.busy}, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      bus.start = 1'b0;
      bus.dvs   = '0;
      bus.quo   = '0;
      bus.rem   = '0;

      // Asynchronous reset before any clock edge.
      #2 rst = 1'b1;
      #1;
      check("reset busy", {31'd0, bus.busy}, 0);
      check("reset done", {31'd0, bus.done}, 0);
      check("reset prod", {16'd0, bus.prod}, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Typical operation and result hold.
      issue(8'd7, 8'd28, 4'd4, 16'd200, 1'b1);
      wait_done(0, "typical");
      @(posedge clk);
      #1;
      check("typical done one cycle", {31'd0, bus.done}, 0);
      check("typical prod hold", {16'd0, bus.prod}, 200);

      // Extremes.
      issue(8'd255, 8'd255, 4'd15, 16'd65040, 1'b1);
      wait_done(0, "max");
      issue(8'd0, 8'd255, 4'd9, 16'd9, 1'b1);
      wait_done(0, "zero dvs");

      // Start while busy at E3 must be ignored.
      issue(8'd7, 8'd28, 4'd4, 16'd200, 1'b1);
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      bus.start = 1'b1;
      bus.dvs   = 8'd1;
      bus.quo   = 8'd1;
      bus.rem   = 4'd0;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      wait_done(3, "ignored");

      // Back-to-back: start during the done cycle.
      issue(8'd3, 8'd5, 4'd1, 16'd16, 1'b1);
      wait_done(0, "b2b");

      // Reset mid-run: no done, busy/prod cleared asynchronously.
      issue(8'd7, 8'd28, 4'd4, 16'd200, 1'b0);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      #3 rst = 1'b1;
      #1;
      check("midreset busy", {31'd0, bus.busy}, 0);
      check("midreset prod", {16'd0, bus.prod}, 0);
      check("midreset done", {31'd0, bus.done}, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         check("no done after reset", {31'd0, bus.done}, 0);
      end

      issue(8'd3, 8'd5, 4'd1, 16'd16, 1'b1);
      wait_done(0, "after reset");

      repeat (3) @(negedge clk);
      check("scoreboard drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
